// File: rtl/e_gpu_pkg.sv
// Shared constants and helpers for the GPU response path.
package e_gpu_pkg;

  // Width of the response-arbiter stall counter.
  localparam int RSP_ARB_PERF_WIDTH = 64;

  // Output tag width: the source tag plus the index of the winning source.
  function automatic int rsp_arb_tag_out_width(input int tag_in_width, input int num_inputs);
    return tag_in_width + $clog2(num_inputs);
  endfunction

endpackage

// File: rtl/vx_cache_rsp_if.sv
// Cache response bundle: NUM_REQS lanes, each with valid/data/tag and a ready.
// Handshake: a lane transfers on a cycle where valid and ready are both high;
// the master holds data/tag stable while valid is high and ready is low, and
// ready may depend combinationally on valid.
interface VX_cache_rsp_if #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
);
  logic [NUM_REQS-1:0]                 valid;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  tag;
  logic [NUM_REQS-1:0]                 ready;

  modport master (output valid, output data, output tag, input ready);
  modport slave  (input valid, input data, input tag, output ready);
endinterface

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the pointer with
// wrap-around; the pointer moves to (winner + 1) mod NUM_INPUTS on advance.
module vx_rr_arbiter #(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] requests,
  input  logic                  advance,
  output logic [NUM_INPUTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]      grant_index
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;

  // Priority search starting at ptr; the first requesting input wins.
  always_comb begin
    int  idx;
    logic found;
    grant_onehot = '0;
    grant_index  = '0;
    found        = 1'b0;
    idx          = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!found && requests[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_index       = IDX_W'(idx);
      end
    end
  end

  // Next pointer wraps explicitly so non-power-of-2 input counts work.
  always_comb begin
    ptr_next = ptr;
    if (advance) begin
      if (grant_index == IDX_W'(NUM_INPUTS - 1)) ptr_next = '0;
      else                                       ptr_next = grant_index + IDX_W'(1);
    end
  end

  // Pointer register; frozen unless an accept happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

endmodule

// File: rtl/vx_cache_rsp_arb.sv
// Per-lane round-robin merge of NUM_INPUTS cache response ports into one.
// Each lane has its own arbiter and a one-entry output register; the winning
// source index is prepended to the tag. Optional build macro:
// E_GPU_RSP_ARB_PERF_EN adds perf_stall_cycles (saturating count of cycles
// where any lane holds a valid output that is not accepted).
module vx_cache_rsp_arb
  import e_gpu_pkg::*;
#(
  parameter int NUM_INPUTS    = 2,
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int TAG_OUT_WIDTH = rsp_arb_tag_out_width(TAG_IN_WIDTH, NUM_INPUTS)
) (
  input  logic           clk,
  input  logic           reset,
  VX_cache_rsp_if.slave  rsp_in_if [NUM_INPUTS],
  VX_cache_rsp_if.master rsp_out_if
`ifdef E_GPU_RSP_ARB_PERF_EN
  ,
  output logic [RSP_ARB_PERF_WIDTH-1:0] perf_stall_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                   in_valid;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][DATA_WIDTH-1:0]   in_data;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0][TAG_IN_WIDTH-1:0] in_tag;
  logic [NUM_INPUTS-1:0][NUM_REQS-1:0]                   in_ready;

  logic [NUM_REQS-1:0]                    out_valid;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    out_data;
  logic [NUM_REQS-1:0][TAG_OUT_WIDTH-1:0] out_tag;
  logic [NUM_REQS-1:0]                    out_ready;

  // Flatten the source interfaces into plain arrays.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_src
    assign in_valid[i]        = rsp_in_if[i].valid;
    assign in_data[i]         = rsp_in_if[i].data;
    assign in_tag[i]          = rsp_in_if[i].tag;
    assign rsp_in_if[i].ready = in_ready[i];
  end

  assign rsp_out_if.valid = out_valid;
  assign rsp_out_if.data  = out_data;
  assign rsp_out_if.tag   = out_tag;
  assign out_ready        = rsp_out_if.ready;

  for (genvar l = 0; l < NUM_REQS; l++) begin : g_lane
    logic [NUM_INPUTS-1:0]    lane_req;
    logic [NUM_INPUTS-1:0]    grant_onehot;
    logic [IDX_W-1:0]         grant_index;
    logic                     can_load;
    logic                     accept;
    logic                     valid_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [TAG_OUT_WIDTH-1:0] tag_q;

    // Gather this lane's request bits across all sources.
    always_comb begin
      lane_req = '0;
      for (int i = 0; i < NUM_INPUTS; i++) lane_req[i] = in_valid[i][l];
    end

    // The stage can load when empty or draining this cycle; reset blocks all loads.
    assign can_load = !valid_q || out_ready[l];
    assign accept   = (|lane_req) && can_load && !reset;

    vx_rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS)
    ) u_arb (
      .clk          (clk),
      .reset        (reset),
      .requests     (lane_req),
      .advance      (accept),
      .grant_onehot (grant_onehot),
      .grant_index  (grant_index)
    );

    // Only the granted source sees ready, and only when the stage can load.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_rdy
      assign in_ready[i][l] = grant_onehot[i] && can_load && !reset;
    end

    // Output register: load on accept, clear on drain without refill.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (accept) begin
        valid_q <= 1'b1;
        data_q  <= in_data[grant_index][l];
        tag_q   <= TAG_OUT_WIDTH'({grant_index, in_tag[grant_index][l]});
      end else if (out_ready[l]) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid[l] = valid_q;
    assign out_data[l]  = data_q;
    assign out_tag[l]   = tag_q;
  end

`ifdef E_GPU_RSP_ARB_PERF_EN
  logic [RSP_ARB_PERF_WIDTH-1:0] perf_q;
  logic                          any_stall;

  assign any_stall = |(out_valid & ~out_ready);

  // Saturating count of cycles where some lane is stalled by the consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          perf_q <= '0;
    else if (any_stall && perf_q != '1) perf_q <= perf_q + RSP_ARB_PERF_WIDTH'(1);
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_vx_cache_rsp_arb.sv
// Directed bench for vx_cache_rsp_arb with three sources and four lanes.
module tb_vx_cache_rsp_arb;

  localparam int NI  = 3;
  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int TOW = 10;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0][NR-1:0]         src_valid;
  logic [NI-1:0][NR-1:0][DW-1:0] src_data;
  logic [NI-1:0][NR-1:0][TW-1:0] src_tag;
  logic [NI-1:0][NR-1:0]         src_ready;
  logic [NR-1:0]                 out_ready;

  VX_cache_rsp_if #(.NUM_REQS(NR), .DATA_WIDTH(DW), .TAG_WIDTH(TW))  in_if [NI] ();
  VX_cache_rsp_if #(.NUM_REQS(NR), .DATA_WIDTH(DW), .TAG_WIDTH(TOW)) out_if ();

  for (genvar i = 0; i < NI; i++) begin : g_drv
    assign in_if[i].valid = src_valid[i];
    assign in_if[i].data  = src_data[i];
    assign in_if[i].tag   = src_tag[i];
    assign src_ready[i]   = in_if[i].ready;
  end
  assign out_if.ready = out_ready;

`ifdef E_GPU_RSP_ARB_PERF_EN
  logic [63:0] perf_stall_cycles;
`endif

  vx_cache_rsp_arb #(
    .NUM_INPUTS   (NI),
    .NUM_REQS     (NR),
    .DATA_WIDTH   (DW),
    .TAG_IN_WIDTH (TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rsp_in_if  (in_if),
    .rsp_out_if (out_if)
`ifdef E_GPU_RSP_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_data  = '0;
    src_tag   = '0;
  endtask

  task automatic drive(input int i, input int l, input logic [DW-1:0] d, input logic [TW-1:0] t);
    src_valid[i][l] = 1'b1;
    src_data[i][l]  = d;
    src_tag[i][l]   = t;
  endtask

  function automatic logic [2:0] lane_rdy(input int l);
    return {src_ready[2][l], src_ready[1][l], src_ready[0][l]};
  endfunction

  initial begin
    logic [1:0] g;
    logic [1:0] bp_seq[4];
    clear_src();
    out_ready = '1;

    // Reset state, readies low while reset is high even with a request
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_if.valid), 64'h0);
    check("rst_data0", 64'(out_if.data[0]), 64'h0);
    check("rst_tag0", 64'(out_if.tag[0]), 64'h0);
    drive(0, 0, 32'h1, 8'h1);
    #1;
    check("rst_ready", 64'(src_ready), 64'h0);
    clear_src();
    reset = 1'b0;
    step();

`ifdef E_GPU_RSP_ARB_PERF_EN
    // 7 stall cycles on lane 3 overlapped by 2 on lane 1
    check("perf_init", perf_stall_cycles, 64'd0);
    out_ready = 4'b0101;
    drive(2, 3, 32'h77, 8'h07);
    step();
    clear_src();
    for (int k = 0; k < 7; k++) begin
      if (k == 2) drive(2, 1, 32'h11, 8'h01);
      if (k == 3) clear_src();
      if (k == 5) out_ready[1] = 1'b1;
      step();
    end
    out_ready = '1;
    step();
    check("perf_stall", perf_stall_cycles, 64'd7);
    check("perf_drained", 64'(out_if.valid), 64'h0);
    step();
    check("perf_hold", perf_stall_cycles, 64'd7);
`endif

    // Single source on lane 2
    drive(1, 2, 32'hDEADBEEF, 8'h5A);
    #1;
    check("single_rdy", 64'(lane_rdy(2)), 64'h2);
    step();
    clear_src();
    check("single_valid", 64'(out_if.valid), 64'h4);
    check("single_data", 64'(out_if.data[2]), 64'hDEADBEEF);
    check("single_tag", 64'(out_if.tag[2]), 64'h15A);
    step();
    check("single_clear", 64'(out_if.valid), 64'h0);

    // Fairness on lane 0: all three sources valid, output always ready
    for (int i = 0; i < NI; i++) drive(i, 0, 32'hA0 + 32'(i), 8'h10 + 8'(i));
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    while (exp_q.size() > 0) begin
      #1;
      check("fair_rdy", 64'(lane_rdy(0)), 64'(3'b001 << exp_q[0]));
      step();
      g = exp_q.pop_front();
      check("fair_valid", 64'(out_if.valid[0]), 64'h1);
      check("fair_tag", 64'(out_if.tag[0]), 64'({g, 8'h10 + 8'(g)}));
      check("fair_data", 64'(out_if.data[0]), 64'h0A0 + 64'(g));
    end
    clear_src();
    step();
    check("fair_drain", 64'(out_if.valid[0]), 64'h0);

    // Backpressure on lane 0 with sources 0 and 1 valid
    out_ready[0] = 1'b0;
    drive(0, 0, 32'h100, 8'h20);
    drive(1, 0, 32'h101, 8'h21);
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_rdy", 64'(lane_rdy(0)), 64'h0);
      check("bp_tag", 64'(out_if.tag[0]), 64'h020);
      check("bp_data", 64'(out_if.data[0]), 64'h100);
      step();
    end
    out_ready[0] = 1'b1;
    bp_seq = '{2'd1, 2'd0, 2'd1, 2'd0};
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_rel_valid", 64'(out_if.valid[0]), 64'h1);
      check("bp_rel_tag", 64'(out_if.tag[0]), 64'({bp_seq[k], 8'h20 + 8'(bp_seq[k])}));
      check("bp_rel_data", 64'(out_if.data[0]), 64'h100 + 64'(bp_seq[k]));
    end
    clear_src();
    step();

    // Lane independence: lane 0 stalled, lane 1 at full rate
    out_ready = 4'b1110;
    drive(2, 0, 32'h200, 8'h33);
    drive(0, 0, 32'h210, 8'h34);
    drive(0, 1, 32'h300, 8'h40);
    drive(1, 1, 32'h301, 8'h41);
    #1;
    check("ind_rdy0", 64'(lane_rdy(0)), 64'h4);
    step();
    check("ind_l1_first", 64'(out_if.tag[1]), 64'h040);
    exp_q = '{2'd1, 2'd0, 2'd1, 2'd0};
    while (exp_q.size() > 0) begin
      check("ind_l0_rdy", 64'(lane_rdy(0)), 64'h0);
      step();
      g = exp_q.pop_front();
      check("ind_l1_valid", 64'(out_if.valid[1]), 64'h1);
      check("ind_l1_tag", 64'(out_if.tag[1]), 64'({g, 8'h40 + 8'(g)}));
      check("ind_l0_tag", 64'(out_if.tag[0]), 64'h233);
    end
    out_ready[0] = 1'b1;
    #1;
    check("ind_l0_resume_rdy", 64'(lane_rdy(0)), 64'h1);
    step();
    check("ind_l0_resume_tag", 64'(out_if.tag[0]), 64'h034);
    check("ind_l0_resume_data", 64'(out_if.data[0]), 64'h210);
    clear_src();
    step();

    // Reset asserted mid-transfer with lane 0 holding a stalled response
    out_ready[0] = 1'b0;
    drive(1, 0, 32'h55, 8'h66);
    step();
    check("mid_pre_valid", 64'(out_if.valid[0]), 64'h1);
    for (int i = 0; i < NI; i++) drive(i, 0, 32'h400 + 32'(i), 8'h50 + 8'(i));
    #2;
    reset = 1'b1;
    #1;
    check("mid_valid", 64'(out_if.valid), 64'h0);
    check("mid_data0", 64'(out_if.data[0]), 64'h0);
    check("mid_tag0", 64'(out_if.tag[0]), 64'h0);
    check("mid_rdy", 64'(src_ready), 64'h0);
    step();
    check("mid_hold_valid", 64'(out_if.valid), 64'h0);
    reset = 1'b0;
    out_ready = '1;
    #1;
    check("post_rst_rdy", 64'(lane_rdy(0)), 64'h1);
    step();
    check("post_rst_tag", 64'(out_if.tag[0]), 64'h050);
    check("post_rst_data", 64'(out_if.data[0]), 64'h400);
    clear_src();
    step();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
